ahb_lcd_dma: RTL and testbench

AHB_LCD_DMA -- requirements
Module: ahb_lcd_dma

---
 rtl/ahb_lcd_dma_if.sv | 30 +++
 rtl/ahb_lcd_dma.sv | 143 ++++++++++++++
 tb/tb_ahb_lcd_dma.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lcd_dma_if.sv
// AHB-lite master/slave signal bundle for the BRAM-to-LCD DMA engine.
// Signal names follow the AHB port names used by the DMA block.
`ifndef W_BURST
`define W_BURST 3
`endif

interface ahb_lcd_dma_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0]   o_HADDR;
    logic [W_DATA-1:0]   o_HWDATA;
    logic                o_HWRITE;
    logic [2:0]          o_HSIZE;
    logic [`W_BURST-1:0] o_HBURST;
    logic [1:0]          o_HTRANS;
    logic [W_DATA-1:0]   i_HRDATA;
    logic                i_HREADY;
    logic [1:0]          i_HRESP;

    modport master (
        output o_HADDR, o_HWDATA, o_HWRITE, o_HSIZE, o_HBURST, o_HTRANS,
        input  i_HRDATA, i_HREADY, i_HRESP
    );

    modport slave (
        input  o_HADDR, o_HWDATA, o_HWRITE, o_HSIZE, o_HBURST, o_HTRANS,
        output i_HRDATA, i_HREADY, i_HRESP
    );
endinterface

// File: rtl/ahb_lcd_dma.sv
// AHB-lite DMA master: copies n_words words from BRAM (src_base, +4, ...) to one LCD register.
// Define DMA_ERR_ABORT_EN to flag ERROR responses in err and abort the remaining words.
module ahb_lcd_dma #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int W_CNT  = 17
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [W_ADDR-1:0] src_base,
    input  logic [W_ADDR-1:0] dst_addr,
    input  logic [W_CNT-1:0]  n_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    ahb_lcd_dma_if.master     bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE} state_t;

    state_t            state;
    logic [W_ADDR-1:0] src_q, dst_q, haddr_q;
    logic [W_CNT-1:0]  total_q, xfer_q;
    logic [W_DATA-1:0] data_q;
    logic [1:0]        htrans_q;
    logic              hwrite_q;
    logic              resp_err;
    logic [W_CNT-1:0]  xfer_next;
    logic [W_ADDR-1:0] src_next;

`ifdef DMA_ERR_ABORT_EN
    assign resp_err = (bus.i_HRESP == 2'b01);
`else
    logic unused_resp;
    assign unused_resp = ^bus.i_HRESP;
    assign resp_err    = 1'b0;
`endif

    // Source address wraps naturally at the W_ADDR boundary.
    assign xfer_next = xfer_q + W_CNT'(1);
    assign src_next  = src_q + W_ADDR'(4);

    assign bus.o_HADDR  = haddr_q;
    assign bus.o_HWDATA = data_q;
    assign bus.o_HWRITE = hwrite_q;
    assign bus.o_HTRANS = htrans_q;
    assign bus.o_HSIZE  = 3'b010;
    assign bus.o_HBURST = '0;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            total_q  <= '0;
            xfer_q   <= '0;
            data_q   <= '0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (n_words != '0) begin
                            src_q    <= src_base;
                            dst_q    <= dst_addr;
                            total_q  <= n_words;
                            xfer_q   <= '0;
                            haddr_q  <= src_base;
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b0;
                            state    <= RD_ADDR;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.i_HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (resp_err) err <= 1'b1;
                    if (bus.i_HREADY) begin
                        // An error seen in the wait cycle of a two-cycle ERROR still aborts.
                        if (resp_err || err) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            data_q   <= bus.i_HRDATA;
                            haddr_q  <= dst_q;
                            hwrite_q <= 1'b1;
                            htrans_q <= HTRANS_NONSEQ;
                            state    <= WR_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (bus.i_HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        state    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (resp_err) err <= 1'b1;
                    if (bus.i_HREADY) begin
                        xfer_q   <= xfer_next;
                        src_q    <= src_next;
                        hwrite_q <= 1'b0;
                        if (xfer_next == total_q || resp_err || err) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            haddr_q  <= src_next;
                            htrans_q <= HTRANS_NONSEQ;
                            state    <= RD_ADDR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lcd_dma.sv
// Directed bench for ahb_lcd_dma: an AHB slave model with wait/error injection logs every
// completed transfer, and one task per scenario compares the logs against hand-derived values.
module tb_ahb_lcd_dma;
    localparam logic [31:0] DST = 32'h4000_0010;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_addr = '0;
    logic [16:0] n_words = '0;
    logic        busy, done, err;

    ahb_lcd_dma_if #(.W_ADDR(32), .W_DATA(32)) bus ();

    ahb_lcd_dma #(.W_ADDR(32), .W_DATA(32), .W_CNT(17)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .start    (start),
        .src_base (src_base),
        .dst_addr (dst_addr),
        .n_words  (n_words),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_waits  = 0;
    int err_rd_idx = -1;

    logic [31:0] rd_addr [64];
    logic [31:0] rd_data [64];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          ns_cyc  [256];
    int rd_n = 0, wr_n = 0, ns_n = 0, done_n = 0, busy_n = 0, unstable_n = 0, done_cyc = 0;

    logic        dph = 1'b0, dph_first = 1'b0, dph_wr = 1'b0, dph_err = 1'b0;
    logic [31:0] dph_addr = '0, hold_addr = '0, hold_wdata = '0;
    int          wcnt = 0;

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5AC3};
    endfunction

    always @(posedge HCLK) cyc <= cyc + 1;

    // Slave model and bus monitor: address and data phases never overlap in this master.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph          = 1'b0;
            wcnt         = 0;
            bus.i_HREADY = 1'b1;
            bus.i_HRESP  = 2'b00;
            bus.i_HRDATA = '0;
        end else begin
            bus.i_HRESP  = 2'b00;
            bus.i_HREADY = 1'b1;
            if (dph) begin
                if (dph_first) begin
                    hold_addr  = bus.o_HADDR;
                    hold_wdata = bus.o_HWDATA;
                    dph_first  = 1'b0;
                end else if (bus.o_HADDR !== hold_addr || bus.o_HWDATA !== hold_wdata) begin
                    unstable_n++;
                end
                if (!dph_wr) bus.i_HRDATA = rd_pat(dph_addr);
                if (dph_err) begin
                    bus.i_HRESP  = 2'b01;
                    bus.i_HREADY = (wcnt != 0);
                    wcnt++;
                end else if (wcnt < n_waits) begin
                    bus.i_HREADY = 1'b0;
                    wcnt++;
                end
                if (bus.i_HREADY) begin
                    if (dph_wr) begin
                        if (wr_n < 64) begin
                            wr_addr[wr_n] = dph_addr;
                            wr_data[wr_n] = bus.o_HWDATA;
                        end
                        wr_n++;
                    end else begin
                        if (rd_n < 64) begin
                            rd_addr[rd_n] = dph_addr;
                            rd_data[rd_n] = bus.i_HRDATA;
                        end
                        rd_n++;
                    end
                    dph = 1'b0;
                end
            end else if (bus.o_HTRANS == 2'b10) begin
                dph       = 1'b1;
                dph_first = 1'b1;
                dph_wr    = bus.o_HWRITE;
                dph_addr  = bus.o_HADDR;
                dph_err   = !bus.o_HWRITE && (rd_n == err_rd_idx);
                wcnt      = 0;
                if (ns_n < 256) ns_cyc[ns_n] = cyc;
                ns_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (busy) busy_n++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #2;
        end
    endtask

    // Holds start for one cycle; c0 is the cycle in which start is sampled.
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [16:0] n,
                               output int c0);
        @(posedge HCLK);
        #2;
        start    = 1'b1;
        src_base = s;
        dst_addr = d;
        n_words  = n;
        c0       = cyc;
        @(posedge HCLK);
        #2;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done_n > base) ok = 1'b1;
            else tick(1);
        end
        if (done_n > base) ok = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (bus.o_HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %b want 00", bus.o_HTRANS); end
        n_checks++; if (bus.o_HADDR !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h want 0", bus.o_HADDR); end
        n_checks++; if (bus.o_HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata: got %h want 0", bus.o_HWDATA); end
        n_checks++; if (bus.o_HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite: got %b want 0", bus.o_HWRITE); end
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        HRESETn = 1'b1;
        tick(2);
        n_checks++; if (bus.o_HSIZE !== 3'b010) begin n_fail++; $display("FAIL hsize: got %b want 010", bus.o_HSIZE); end
        n_checks++; if (bus.o_HBURST !== 3'b000) begin n_fail++; $display("FAIL hburst: got %b want 000", bus.o_HBURST); end
    endtask

    // Copies n words from s and checks read addresses, write address/data and done timing.
    task automatic run_copy(input string name, input logic [31:0] s, input int n, input int cyc_per_word);
        int c0, rb, wb, nb, db;
        bit ok;
        rb = rd_n; wb = wr_n; nb = ns_n; db = done_n;
        pulse_start(s, DST, 17'(n), c0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", name, busy); end
        wait_done(db, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_done_timeout: got no done want done", name); end
        tick(3);
        n_checks++; if (ns_cyc[nb] !== c0 + 1) begin n_fail++; $display("FAIL %s_first_nonseq: got cycle %0d want %0d", name, ns_cyc[nb], c0 + 1); end
        n_checks++; if (done_cyc - ns_cyc[nb] !== n * cyc_per_word) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, done_cyc - ns_cyc[nb], n * cyc_per_word); end
        n_checks++; if (rd_n - rb !== n || wr_n - wb !== n) begin n_fail++; $display("FAIL %s_counts: got rd %0d wr %0d want %0d", name, rd_n - rb, wr_n - wb, n); end
        for (int k = 0; k < n; k++) begin
            n_checks++; if (rd_addr[rb + k] !== s + 32'(4 * k)) begin n_fail++; $display("FAIL %s_rd_addr%0d: got %h want %h", name, k, rd_addr[rb + k], s + 32'(4 * k)); end
            n_checks++; if (wr_addr[wb + k] !== DST) begin n_fail++; $display("FAIL %s_wr_addr%0d: got %h want %h", name, k, wr_addr[wb + k], DST); end
            n_checks++; if (wr_data[wb + k] !== rd_pat(s + 32'(4 * k))) begin n_fail++; $display("FAIL %s_wr_data%0d: got %h want %h", name, k, wr_data[wb + k], rd_pat(s + 32'(4 * k))); end
        end
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", name, done_n - db); end
        n_checks++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL %s_idle_flags: got %b want 00", name, {busy, err}); end
    endtask

    task automatic test_basic();
        run_copy("basic", 32'h0, 4, 4);
    endtask

    task automatic test_wrap();
        run_copy("wrap", 32'hFFFF_FFF8, 3, 4);
    endtask

    // Two waits per data phase: each word costs 1 + 3 + 1 + 3 cycles.
    task automatic test_wait_states();
        int ub, wb;
        ub = unstable_n; wb = wr_n;
        n_waits = 2;
        run_copy("waits", 32'h40, 2, 8);
        n_waits = 0;
        n_checks++; if (unstable_n - ub !== 0) begin n_fail++; $display("FAIL waits_stable: got %0d changes want 0", unstable_n - ub); end
        n_checks++; if (wr_data[wb + 1] !== rd_data[rd_n - 1]) begin n_fail++; $display("FAIL waits_wr_eq_rd: got %h want %h", wr_data[wb + 1], rd_data[rd_n - 1]); end
    endtask

    task automatic test_zero_words();
        int c0, nb, bb, db;
        nb = ns_n; bb = busy_n; db = done_n;
        pulse_start(32'h100, DST, 17'd0, c0);
        n_checks++; if ({done, busy} !== 2'b11) begin n_fail++; $display("FAIL zero_done_cycle: got done,busy %b want 11", {done, busy}); end
        tick(1);
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_after: got done,busy %b want 00", {done, busy}); end
        tick(4);
        n_checks++; if (ns_n - nb !== 0) begin n_fail++; $display("FAIL zero_no_nonseq: got %0d want 0", ns_n - nb); end
        n_checks++; if (busy_n - bb !== 1) begin n_fail++; $display("FAIL zero_busy_len: got %0d want 1", busy_n - bb); end
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_n - db); end
    endtask

    task automatic test_back_to_back();
        int c0, c1, rb, wb, nb, db;
        bit ok;
        rb = rd_n; wb = wr_n; nb = ns_n; db = done_n;
        pulse_start(32'h200, DST, 17'd3, c0);
        for (int i = 0; i < 50 && rd_n - rb < 2; i++) tick(1);
        pulse_start(32'h900, DST, 17'd5, c1);
        wait_done(db, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done_timeout: got no done want done"); end
        tick(20);
        n_checks++; if (wr_n - wb !== 3) begin n_fail++; $display("FAIL b2b_writes: got %0d want 3", wr_n - wb); end
        n_checks++; if (ns_n - nb !== 6) begin n_fail++; $display("FAIL b2b_nonseq: got %0d want 6", ns_n - nb); end
        n_checks++; if (rd_addr[rb + 2] !== 32'h208) begin n_fail++; $display("FAIL b2b_rd_addr2: got %h want 208", rd_addr[rb + 2]); end
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_n - db); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int c0, nb, db;
        rb_wait: for (int i = 0; i < 50; i++) begin
            if (i == 0) pulse_start(32'h80, DST, 17'd2, c0);
            if (bus.o_HTRANS == 2'b10 && bus.o_HWRITE == 1'b1) break;
            tick(1);
        end
        n_checks++; if (bus.o_HWRITE !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wr_addr: got hwrite %b want 1", bus.o_HWRITE); end
        HRESETn = 1'b0;
        #1;
        n_checks++; if (bus.o_HTRANS !== 2'b00) begin n_fail++; $display("FAIL rstmid_htrans: got %b want 00", bus.o_HTRANS); end
        n_checks++; if ({bus.o_HWRITE, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {bus.o_HWRITE, busy, done}); end
        n_checks++; if (bus.o_HADDR !== 32'h0) begin n_fail++; $display("FAIL rstmid_haddr: got %h want 0", bus.o_HADDR); end
        tick(1);
        HRESETn = 1'b1;
        nb = ns_n; db = done_n;
        tick(20);
        n_checks++; if (done_n - db !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_n - db); end
        n_checks++; if (ns_n - nb !== 0) begin n_fail++; $display("FAIL rstmid_no_nonseq: got %0d want 0", ns_n - nb); end
    endtask

    task automatic test_err();
        int c0, rb, wb, db;
        bit ok;
        rb = rd_n; wb = wr_n; db = done_n;
        err_rd_idx = rd_n;
        pulse_start(32'h300, DST, 17'd4, c0);
        wait_done(db, 200, ok);
        err_rd_idx = -1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL err_done_timeout: got no done want done"); end
        tick(3);
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL err_done_count: got %0d want 1", done_n - db); end
`ifdef DMA_ERR_ABORT_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err); end
        n_checks++; if (wr_n - wb !== 0) begin n_fail++; $display("FAIL err_writes: got %0d want 0", wr_n - wb); end
        n_checks++; if (rd_n - rb !== 1) begin n_fail++; $display("FAIL err_reads: got %0d want 1", rd_n - rb); end
`else
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_flag: got %b want 0", err); end
        n_checks++; if (wr_n - wb !== 4) begin n_fail++; $display("FAIL err_writes: got %0d want 4", wr_n - wb); end
        n_checks++; if (wr_data[wb] !== rd_pat(32'h300)) begin n_fail++; $display("FAIL err_wr_data0: got %h want %h", wr_data[wb], rd_pat(32'h300)); end
`endif
        db = done_n;
        pulse_start(32'h400, DST, 17'd1, c0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        wait_done(db, 50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL err_next_timeout: got no done want done"); end
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_wait_states();
        test_zero_words();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
